sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single external SRAM port between three requesters: the CPU, the video CRT fetch engine and a block DMA engine.
- Each sys_clk cycle is one memory slot, and exactly one requester owns it.
- The CPU is stalled through the cpu68 hold input when it loses a slot.
- Sits between the CPU/bus decode, videocrt, the DMA engine and the sram module, replacing the hard-wired video/CPU mux.

Parameters:
- AW, 16, address width of every requester and of the SRAM-side address.
- DW, 8, data width.
- MAX_STALL, 4, consecutive CPU hold cycles after which the CPU is force-granted one slot (1..15).

Ports:
- clk  in  1  sys_clk; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_ad  in  AW  CPU address.
- cpu_rw  in  1  CPU read(1)/write(0).
- cpu_cs  in  1  CPU RAM access this cycle (en_ram && vma).
- cpu_hold  out  1  stall request to the CPU.
- vid_req  in  1  video fetch request, level.
- vid_ad  in  AW  video fetch address.
- vid_ack  out  1  one-cycle pulse: vid_data valid.
- vid_data  out  DW  fetched video byte.
- dma_req  in  1  DMA request, level.
- dma_ad  in  AW  DMA address.
- dma_rw  in  1  DMA read(1)/write(0).
- dma_wd  in  DW  DMA write data.
- dma_ack  out  1  one-cycle pulse: DMA slot completed.
- dma_data  out  DW  DMA read data.
- cpu_wd  in  DW  CPU write data.
- ram_ad  out  AW  SRAM address.
- ram_rw  out  1  SRAM read(1)/write(0).
- ram_cs  out  1  SRAM select.
- ram_wd  out  DW  SRAM write data.
- ram_rd  in  DW  SRAM read data, valid at end of slot.
- owner  out  2  current slot owner (debug/status).

Behaviour:
- Owner encoding: CPU=0, VID=1, DMA=2.
- Slot owner is combinational per cycle:
  - force_cpu=1 -> CPU.
  - Else vid_req && !vid_mask -> VID.
  - Else dma_req && !dma_mask -> DMA.
  - Else CPU.
- SRAM-side mux follows the owner:
  - VID: ram_ad=vid_ad, ram_rw=1, ram_cs=1.
  - DMA: ram_ad=dma_ad, ram_rw=dma_rw, ram_wd=dma_wd, ram_cs=1.
  - CPU: ram_ad=cpu_ad, ram_rw=cpu_rw, ram_wd=cpu_wd, ram_cs=cpu_cs.
- cpu_hold = cpu_cs && (owner != CPU). It is combinational, and is 0 whenever the CPU is not addressing RAM.
- VID grant: on the slot-ending edge, vid_data<=ram_rd and vid_ack<=1. vid_ack is 1 for exactly the next cycle.
- DMA grant: on the slot-ending edge, dma_ack<=1. For a read, dma_data<=ram_rd; for a write, dma_data holds its previous value.
- Acks clear to 0 on any edge with no grant to that requester.
- Back-to-back masking: vid_mask=vid_ack and dma_mask=dma_ack. A requester is never granted in its own ack cycle.
  - Requesters keep req high until they sample ack, then drop it. This guarantees exactly one access per request.
  - A req still high in the cycle after ack counts as a new request.
- Stall counter stall_cnt (4 bit):
  - Increments on each edge with cpu_hold=1.
  - Clears on each edge with cpu_hold=0.
  - force_cpu = (stall_cnt == MAX_STALL).
  - While force_cpu is set, cpu_hold=0, so the counter clears after that slot. The CPU therefore gets one slot in every MAX_STALL+1.
- Simultaneous vid_req and dma_req: VID wins. DMA is served in the VID ack cycle because VID is masked there.
- Continuous VID requests alternate VID/other slots, because of the mask, so they cannot starve DMA.
- Reset (rst=1 at an edge):
  - vid_ack=0, dma_ack=0, vid_data=0, dma_data=0, stall_cnt=0.
  - Masks clear.
  - While rst is high: owner=CPU, cpu_hold=0, ram_cs=0.
- Reset mid-transfer: the in-flight slot is dropped with no ack. The requester must re-request after reset.

Decomposition:
- Shared package: owner encoding constants (OWN_CPU, OWN_VID, OWN_DMA) and the default AW/DW.
- No sub-module is needed. The priority/stall logic and the data latches are one flat block of about 150–200 lines.

Test Plan:
- CPU-only read at $1234, no other requests -> ram_ad=$1234, ram_cs=1, cpu_hold=0 every cycle, owner=0.
- vid_req with vid_ad=$8000, ram_rd=$A5, cpu_cs=1 -> cycle0: owner=1, ram_ad=$8000, cpu_hold=1; cycle1: vid_ack=1, vid_data=$A5, cpu_hold=0 (masked), vid_req dropped -> exactly one fetch.
- vid_req and dma_req raised together (DMA write $3C to $0400) -> slot0 VID, slot1 DMA with ram_rw=0, ram_wd=$3C; dma_ack at slot2.
- vid_req and dma_req held high with cpu_cs=1, MAX_STALL=4 -> cpu_hold high 4 cycles, then 1 forced CPU slot (owner=0, cpu_hold=0); the pattern repeats every 5 cycles.
- rst asserted during a granted DMA slot -> next cycle: dma_ack=0, ram_cs=0, cpu_hold=0, stall_cnt=0; after rst drops, the held dma_req is granted within 1 cycle.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM slot arbiter: owner encoding and default widths.
package sram_arbiter_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;

    localparam logic [1:0] OWN_CPU = 2'd0;
    localparam logic [1:0] OWN_VID = 2'd1;
    localparam logic [1:0] OWN_DMA = 2'd2;

endpackage

// File: rtl/sram_arbiter.sv
// Slot arbiter for the single SRAM port. Every sys_clk cycle is one slot owned by
// the CPU, the video fetch engine or the DMA engine. The CPU is stalled with
// cpu_hold when it wants RAM but loses the slot, and it is force-granted after
// MAX_STALL consecutive stalls.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_STALL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_ad,
    input  logic          cpu_rw,
    input  logic          cpu_cs,
    output logic          cpu_hold,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_ad,
    output logic          vid_ack,
    output logic [DW-1:0] vid_data,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_ad,
    input  logic          dma_rw,
    input  logic [DW-1:0] dma_wd,
    output logic          dma_ack,
    output logic [DW-1:0] dma_data,
    input  logic [DW-1:0] cpu_wd,
    output logic [AW-1:0] ram_ad,
    output logic          ram_rw,
    output logic          ram_cs,
    output logic [DW-1:0] ram_wd,
    input  logic [DW-1:0] ram_rd,
    output logic [1:0]    owner
);

    logic          vid_ack_q, vid_ack_d;
    logic          dma_ack_q, dma_ack_d;
    logic [DW-1:0] vid_data_q, vid_data_d;
    logic [DW-1:0] dma_data_q, dma_data_d;
    logic [3:0]    stall_cnt_q, stall_cnt_d;
    logic          force_cpu;
    logic [1:0]    own;

    assign force_cpu = (stall_cnt_q == 4'(MAX_STALL));

    // Slot owner: forced CPU slot first, then video, then DMA; a requester is
    // masked in its own ack cycle so continuous video cannot starve DMA.
    always_comb begin
        own = OWN_CPU;
        if (rst || force_cpu)
            own = OWN_CPU;
        else if (vid_req && !vid_ack_q)
            own = OWN_VID;
        else if (dma_req && !dma_ack_q)
            own = OWN_DMA;
    end

    // SRAM-side mux follows the owner; the port is deselected while in reset.
    always_comb begin
        ram_ad = cpu_ad;
        ram_rw = cpu_rw;
        ram_wd = cpu_wd;
        ram_cs = cpu_cs;
        unique case (own)
            OWN_VID: begin
                ram_ad = vid_ad;
                ram_rw = 1'b1;
                ram_cs = 1'b1;
            end
            OWN_DMA: begin
                ram_ad = dma_ad;
                ram_rw = dma_rw;
                ram_wd = dma_wd;
                ram_cs = 1'b1;
            end
            default: ;
        endcase
        if (rst)
            ram_cs = 1'b0;
    end

    assign cpu_hold = !rst && cpu_cs && (own != OWN_CPU);

    // Next-state for acks, read-data latches and the consecutive-stall counter.
    always_comb begin
        vid_ack_d   = (own == OWN_VID);
        dma_ack_d   = (own == OWN_DMA);
        vid_data_d  = vid_data_q;
        dma_data_d  = dma_data_q;
        stall_cnt_d = cpu_hold ? stall_cnt_q + 4'd1 : 4'd0;
        if (own == OWN_VID)
            vid_data_d = ram_rd;
        if (own == OWN_DMA && dma_rw)
            dma_data_d = ram_rd;
    end

    // State registers; reset drops any in-flight slot without an ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            vid_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            vid_data_q  <= '0;
            dma_data_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            vid_ack_q   <= vid_ack_d;
            dma_ack_q   <= dma_ack_d;
            vid_data_q  <= vid_data_d;
            dma_data_q  <= dma_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign vid_ack  = vid_ack_q;
    assign dma_ack  = dma_ack_q;
    assign vid_data = vid_data_q;
    assign dma_data = dma_data_q;
    assign owner    = own;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: inputs change 1 ns after the rising edge,
// outputs are compared on the falling edge against hand-computed values.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_ad, vid_ad, dma_ad, ram_ad;
    logic        cpu_rw, cpu_cs, cpu_hold;
    logic        vid_req, vid_ack, dma_req, dma_rw, dma_ack;
    logic [7:0]  vid_data, dma_wd, dma_data, cpu_wd, ram_wd, ram_rd;
    logic        ram_rw, ram_cs;
    logic [1:0]  owner;

    int n_cmp = 0;
    int n_bad = 0;
    int own_pat [5] = '{1, 2, 1, 2, 0};

    sram_arbiter #(.AW(16), .DW(8), .MAX_STALL(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_ad(cpu_ad), .cpu_rw(cpu_rw), .cpu_cs(cpu_cs), .cpu_hold(cpu_hold),
        .vid_req(vid_req), .vid_ad(vid_ad), .vid_ack(vid_ack), .vid_data(vid_data),
        .dma_req(dma_req), .dma_ad(dma_ad), .dma_rw(dma_rw), .dma_wd(dma_wd),
        .dma_ack(dma_ack), .dma_data(dma_data), .cpu_wd(cpu_wd),
        .ram_ad(ram_ad), .ram_rw(ram_rw), .ram_cs(ram_cs), .ram_wd(ram_wd),
        .ram_rd(ram_rd), .owner(owner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cpu_ad = 16'h1234; cpu_rw = 1'b1; cpu_cs = 1'b1; cpu_wd = 8'h00;
        vid_req = 1'b0; vid_ad = 16'h0; dma_req = 1'b0; dma_ad = 16'h0;
        dma_rw = 1'b1; dma_wd = 8'h00; ram_rd = 8'h00;

        // Reset state, with the CPU addressing RAM to show hold/cs gating.
        tick();
        @(negedge clk);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_hold", 32'(cpu_hold), 32'd0);
        chk("rst_cs", 32'(ram_cs), 32'd0);
        chk("rst_vack", 32'(vid_ack), 32'd0);
        chk("rst_dack", 32'(dma_ack), 32'd0);
        chk("rst_vdata", 32'(vid_data), 32'd0);
        chk("rst_ddata", 32'(dma_data), 32'd0);

        // CPU-only read at $1234.
        for (int i = 0; i < 3; i++) begin
            tick();
            rst = 1'b0;
            @(negedge clk);
            chk("cpu_ad", 32'(ram_ad), 32'h1234);
            chk("cpu_cs", 32'(ram_cs), 32'd1);
            chk("cpu_rw", 32'(ram_rw), 32'd1);
            chk("cpu_hold", 32'(cpu_hold), 32'd0);
            chk("cpu_owner", 32'(owner), 32'd0);
        end

        // Single video fetch stalling the CPU for one slot.
        tick();
        vid_req = 1'b1; vid_ad = 16'h8000; ram_rd = 8'hA5;
        @(negedge clk);
        chk("v_owner", 32'(owner), 32'd1);
        chk("v_ad", 32'(ram_ad), 32'h8000);
        chk("v_rw", 32'(ram_rw), 32'd1);
        chk("v_hold", 32'(cpu_hold), 32'd1);
        tick();
        @(negedge clk);
        chk("v_ack", 32'(vid_ack), 32'd1);
        chk("v_data", 32'(vid_data), 32'hA5);
        chk("v_mask_owner", 32'(owner), 32'd0);
        chk("v_mask_hold", 32'(cpu_hold), 32'd0);
        chk("v_mask_ad", 32'(ram_ad), 32'h1234);
        tick();
        vid_req = 1'b0;
        @(negedge clk);
        chk("v_ack_clr", 32'(vid_ack), 32'd0);
        chk("v_idle_owner", 32'(owner), 32'd0);

        // Simultaneous video and DMA write: VID first, DMA in the VID ack slot.
        tick();
        cpu_cs = 1'b0; vid_req = 1'b1; vid_ad = 16'h8001;
        dma_req = 1'b1; dma_ad = 16'h0400; dma_rw = 1'b0; dma_wd = 8'h3C;
        @(negedge clk);
        chk("vd_owner0", 32'(owner), 32'd1);
        chk("vd_hold0", 32'(cpu_hold), 32'd0);
        tick();
        @(negedge clk);
        chk("vd_vack", 32'(vid_ack), 32'd1);
        chk("vd_owner1", 32'(owner), 32'd2);
        chk("vd_ad1", 32'(ram_ad), 32'h0400);
        chk("vd_rw1", 32'(ram_rw), 32'd0);
        chk("vd_wd1", 32'(ram_wd), 32'h3C);
        chk("vd_cs1", 32'(ram_cs), 32'd1);
        tick();
        vid_req = 1'b0;
        @(negedge clk);
        chk("vd_dack", 32'(dma_ack), 32'd1);
        chk("vd_ddata_hold", 32'(dma_data), 32'd0);
        chk("vd_vack_clr", 32'(vid_ack), 32'd0);
        chk("vd_owner2", 32'(owner), 32'd0);
        chk("vd_cs2", 32'(ram_cs), 32'd0);
        tick();
        dma_req = 1'b0;
        @(negedge clk);
        chk("vd_dack_clr", 32'(dma_ack), 32'd0);

        // Saturating VID+DMA with CPU waiting: 4 stalls then one forced CPU slot.
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0) begin
                cpu_cs = 1'b1; vid_req = 1'b1; dma_req = 1'b1; dma_rw = 1'b1;
            end
            @(negedge clk);
            chk($sformatf("sat_owner%0d", i), 32'(owner), 32'(own_pat[i % 5]));
            chk($sformatf("sat_hold%0d", i), 32'(cpu_hold), 32'(own_pat[i % 5] != 0));
        end

        // Reset during a granted DMA read slot.
        tick();
        vid_req = 1'b0; ram_rd = 8'h5A;
        @(negedge clk);
        chk("rd_owner", 32'(owner), 32'd2);
        chk("rd_rw", 32'(ram_rw), 32'd1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("rr_dack", 32'(dma_ack), 32'd0);
        chk("rr_cs", 32'(ram_cs), 32'd0);
        chk("rr_hold", 32'(cpu_hold), 32'd0);
        chk("rr_owner", 32'(owner), 32'd0);
        chk("rr_ddata", 32'(dma_data), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rr_regrant", 32'(owner), 32'd2);
        tick();
        @(negedge clk);
        chk("rr_dack2", 32'(dma_ack), 32'd1);
        chk("rr_ddata2", 32'(dma_data), 32'h5A);
        chk("rr_mask_owner", 32'(owner), 32'd0);

        // Held DMA req becomes a new write; read data register must keep $5A.
        tick();
        dma_rw = 1'b0; dma_wd = 8'h77;
        @(negedge clk);
        chk("dw_owner", 32'(owner), 32'd2);
        chk("dw_wd", 32'(ram_wd), 32'h77);
        chk("dw_rw", 32'(ram_rw), 32'd0);
        tick();
        dma_req = 1'b0;
        @(negedge clk);
        chk("dw_dack", 32'(dma_ack), 32'd1);
        chk("dw_ddata_hold", 32'(dma_data), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
